ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_master.sv | 188 ++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: core request/response port bridged onto a
// two-stage (address/data) pipelined AHB-Lite bus interface.
module ahb_lite_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    // core request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // core response
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // AHB-Lite
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [1:0]            htrans,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic                  hmastlock,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // address stage
    logic                  a_valid_q, a_valid_d;
    logic [ADDR_WIDTH-1:0] a_addr_q,  a_addr_d;
    logic                  a_write_q, a_write_d;
    logic [1:0]            a_size_q,  a_size_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    // data stage
    logic                  d_valid_q, d_valid_d;
    logic                  d_write_q, d_write_d;
    logic [1:0]            d_size_q,  d_size_d;
    logic [1:0]            d_lane_q,  d_lane_d;
    logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;
    // response and post-reset enable
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  ready_en_q,  ready_en_d;

    logic                  misaligned;
    logic                  accept_bus;
    logic                  accept_mis;
    logic                  retire;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_data;

    assign misaligned = (req_size == 2'd1 && req_addr[0])
                     || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                     || (req_size == 2'd3);

    // A misaligned request waits for an empty pipeline so its error pulse
    // never collides with, or overtakes, a bus completion.
    assign req_ready  = ready_en_q & (misaligned ? (!a_valid_q && !d_valid_q)
                                                 : (!a_valid_q || hready));
    assign accept_bus = req_valid & req_ready & !misaligned;
    assign accept_mis = req_valid & req_ready & misaligned;
    assign retire     = d_valid_q & hready;

    always_comb begin
        case (req_size)
            2'd0:    wdata_rep = {(DATA_WIDTH/8){req_wdata[7:0]}};
            2'd1:    wdata_rep = {(DATA_WIDTH/16){req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    assign rd_shift = hrdata >> {d_lane_q, 3'b000};

    always_comb begin
        case (d_size_q)
            2'd0:    rd_data = {{(DATA_WIDTH-8){1'b0}},  rd_shift[7:0]};
            2'd1:    rd_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
            default: rd_data = rd_shift;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or a fixed value) so no path
        // through this block leaves a signal unassigned and infers a latch.
        a_valid_d   = a_valid_q;
        a_addr_d    = a_addr_q;
        a_write_d   = a_write_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_size_d    = d_size_q;
        d_lane_d    = d_lane_q;
        d_wdata_d   = d_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        ready_en_d  = 1'b1;

        if (hready) begin
            d_valid_d = a_valid_q;
            d_write_d = a_write_q;
            d_size_d  = a_size_q;
            d_lane_d  = a_addr_q[1:0];
            d_wdata_d = a_wdata_q;
            a_valid_d = 1'b0;
        end

        if (accept_bus) begin
            a_valid_d = 1'b1;
            a_addr_d  = req_addr;
            a_write_d = req_write;
            a_size_d  = req_size;
            a_wdata_d = req_write ? wdata_rep : '0;
        end

        if (retire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = hresp;
            rsp_rdata_d = d_write_q ? '0 : rd_data;
        end else if (accept_mis) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid_q   <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_size_q    <= 2'd0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_size_q    <= 2'd0;
            d_lane_q    <= 2'd0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_size_q    <= d_size_d;
            d_lane_q    <= d_lane_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_en_q  <= ready_en_d;
        end
    end

    // Bus outputs come straight from stage flops, gated by the stage valid.
    assign htrans    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = a_valid_q ? a_addr_q : '0;
    assign hsize     = a_valid_q ? {1'b0, a_size_q} : 3'b000;
    assign hwrite    = a_valid_q & a_write_q;
    assign hwdata    = d_valid_q ? d_wdata_q : '0;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a per-cycle vector table followed by
// hand-written stall, error-response and reset sequences.
module tb_ahb_lite_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [3:0]  hprot;

    int errors = 0;
    int checks = 0;

    ahb_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
        .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv, rw;
        logic [31:0] ra;
        logic [1:0]  rs;
        logic [31:0] wd;
        logic        hr, he;
        logic [31:0] hd;
        logic        e_ready;
        logic [1:0]  e_htrans;
        logic [31:0] e_haddr;
        logic [2:0]  e_hsize;
        logic [31:0] e_hwdata;
        logic        e_rv, e_err;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    function automatic vec_t mk(
        input logic rv, input logic rw, input logic [31:0] ra, input logic [1:0] rs,
        input logic [31:0] wd, input logic hr, input logic he, input logic [31:0] hd,
        input logic e_ready, input logic [1:0] e_htrans, input logic [31:0] e_haddr,
        input logic [2:0] e_hsize, input logic [31:0] e_hwdata, input logic e_rv,
        input logic e_err, input logic [31:0] e_rdata);
        vec_t v;
        v.rv = rv; v.rw = rw; v.ra = ra; v.rs = rs; v.wd = wd;
        v.hr = hr; v.he = he; v.hd = hd;
        v.e_ready = e_ready; v.e_htrans = e_htrans; v.e_haddr = e_haddr;
        v.e_hsize = e_hsize; v.e_hwdata = e_hwdata; v.e_rv = e_rv;
        v.e_err = e_err; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic rv, input logic rw, input logic [31:0] ra,
                         input logic [1:0] rs, input logic [31:0] wd,
                         input logic hr, input logic he, input logic [31:0] hd);
        req_valid = rv; req_write = rw; req_addr = ra; req_size = rs; req_wdata = wd;
        hready = hr; hresp = he; hrdata = hd;
    endtask

    task automatic expect_out(input string tag, input logic e_ready, input logic [1:0] e_htrans,
                              input logic [31:0] e_haddr, input logic [2:0] e_hsize,
                              input logic [31:0] e_hwdata, input logic e_rv,
                              input logic e_err, input logic [31:0] e_rdata);
        #1;
        check({tag, ".req_ready"}, {31'b0, req_ready}, {31'b0, e_ready});
        check({tag, ".htrans"},    {30'b0, htrans},    {30'b0, e_htrans});
        check({tag, ".haddr"},     haddr,              e_haddr);
        check({tag, ".hsize"},     {29'b0, hsize},     {29'b0, e_hsize});
        check({tag, ".hwdata"},    hwdata,             e_hwdata);
        check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, {31'b0, e_rv});
        check({tag, ".rsp_err"},   {31'b0, rsp_err},   {31'b0, e_err});
        check({tag, ".rsp_rdata"}, rsp_rdata,          e_rdata);
    endtask

    // One cycle of a hand sequence: drive, check, advance.
    task automatic cyc(input string tag,
                       input logic rv, input logic rw, input logic [31:0] ra,
                       input logic [1:0] rs, input logic [31:0] wd,
                       input logic hr, input logic he, input logic [31:0] hd,
                       input logic e_ready, input logic [1:0] e_htrans,
                       input logic [31:0] e_haddr, input logic [2:0] e_hsize,
                       input logic [31:0] e_hwdata, input logic e_rv,
                       input logic e_err, input logic [31:0] e_rdata);
        apply(rv, rw, ra, rs, wd, hr, he, hd);
        expect_out(tag, e_ready, e_htrans, e_haddr, e_hsize, e_hwdata, e_rv, e_err, e_rdata);
        tick();
    endtask

    initial begin
        // word read, byte write, back-to-back half/byte reads, misaligned cases
        tbl[0]  = mk(1,0,32'h4,2,0, 1,0,0,                  1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[1]  = mk(0,0,0,0,0,     1,0,0,                  1,2'b10,32'h4,2,32'h0,        0,0,32'h0);
        tbl[2]  = mk(0,0,0,0,0,     1,0,32'h12345678,       1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[3]  = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'h0,        1,0,32'h12345678);
        tbl[4]  = mk(1,1,32'h6,0,32'hAB, 1,0,0,             1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[5]  = mk(0,0,0,0,0,     1,0,0,                  1,2'b10,32'h6,0,32'h0,        0,0,32'h0);
        tbl[6]  = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'hABABABAB, 0,0,32'h0);
        tbl[7]  = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'h0,        1,0,32'h0);
        tbl[8]  = mk(1,0,32'h2,1,0, 1,0,0,                  1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[9]  = mk(1,0,32'h3,0,0, 1,0,0,                  1,2'b10,32'h2,1,32'h0,        0,0,32'h0);
        tbl[10] = mk(0,0,0,0,0,     1,0,32'hCAFEBEEF,       1,2'b10,32'h3,0,32'h0,        0,0,32'h0);
        tbl[11] = mk(0,0,0,0,0,     1,0,32'hCAFEBEEF,       1,2'b00,32'h0,0,32'h0,        1,0,32'h0000CAFE);
        tbl[12] = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'h0,        1,0,32'h000000CA);
        tbl[13] = mk(1,0,32'h2,2,0, 1,0,0,                  1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[14] = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'h0,        1,1,32'h0);
        tbl[15] = mk(1,0,32'h0,2,0, 1,0,0,                  1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[16] = mk(1,0,32'h1,1,0, 1,0,0,                  0,2'b10,32'h0,2,32'h0,        0,0,32'h0);
        tbl[17] = mk(1,0,32'h1,1,0, 1,0,32'h11223344,       0,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[18] = mk(1,0,32'h1,1,0, 1,0,0,                  1,2'b00,32'h0,0,32'h0,        1,0,32'h11223344);
        tbl[19] = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'h0,        1,1,32'h0);
        tbl[20] = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[21] = mk(1,0,32'h0,3,0, 1,0,0,                  1,2'b00,32'h0,0,32'h0,        0,0,32'h0);
        tbl[22] = mk(0,0,0,0,0,     1,0,0,                  1,2'b00,32'h0,0,32'h0,        1,1,32'h0);

        // reset state, then req_ready rising one edge after release
        rst_n = 1'b0;
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        #3;
        expect_out("reset", 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check("hburst",    {29'b0, hburst},    32'h0);
        check("hprot",     {28'b0, hprot},     32'h3);
        check("hmastlock", {31'b0, hmastlock}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'b0, req_ready}, 32'h0);
        tick();

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].rv, tbl[i].rw, tbl[i].ra, tbl[i].rs, tbl[i].wd,
                  tbl[i].hr, tbl[i].he, tbl[i].hd);
            expect_out($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_htrans,
                       tbl[i].e_haddr, tbl[i].e_hsize, tbl[i].e_hwdata,
                       tbl[i].e_rv, tbl[i].e_err, tbl[i].e_rdata);
            tick();
        end

        // three back-to-back writes, 2 wait states in the second data phase
        cyc("stall0", 1,1,32'h10,2,32'h11111111, 1,0,0,  1,2'b00,32'h00,0,32'h0,        0,0,0);
        cyc("stall1", 1,1,32'h14,2,32'h22222222, 1,0,0,  1,2'b10,32'h10,2,32'h0,        0,0,0);
        cyc("stall2", 1,1,32'h18,2,32'h33333333, 1,0,0,  1,2'b10,32'h14,2,32'h11111111, 0,0,0);
        cyc("stall3", 0,0,0,0,0,                 0,0,0,  0,2'b10,32'h18,2,32'h22222222, 1,0,0);
        cyc("stall4", 0,0,0,0,0,                 0,0,0,  0,2'b10,32'h18,2,32'h22222222, 0,0,0);
        cyc("stall5", 0,0,0,0,0,                 1,0,0,  1,2'b10,32'h18,2,32'h22222222, 0,0,0);
        cyc("stall6", 0,0,0,0,0,                 1,0,0,  1,2'b00,32'h00,0,32'h33333333, 1,0,0);
        cyc("stall7", 0,0,0,0,0,                 1,0,0,  1,2'b00,32'h00,0,32'h0,        1,0,0);
        cyc("stall8", 0,0,0,0,0,                 1,0,0,  1,2'b00,32'h00,0,32'h0,        0,0,0);

        // two-cycle ERROR on a write, pipelined read still completes
        cyc("err0", 1,1,32'h0,2,32'hDEADBEEF, 1,0,0,            1,2'b00,32'h0,0,32'h0,        0,0,0);
        cyc("err1", 1,0,32'h8,2,0,            1,0,0,            1,2'b10,32'h0,2,32'h0,        0,0,0);
        cyc("err2", 0,0,0,0,0,                0,1,0,            0,2'b10,32'h8,2,32'hDEADBEEF, 0,0,0);
        cyc("err3", 0,0,0,0,0,                1,1,0,            1,2'b10,32'h8,2,32'hDEADBEEF, 0,0,0);
        cyc("err4", 0,0,0,0,0,                1,0,32'h55AA55AA, 1,2'b00,32'h0,0,32'h0,        1,1,0);
        cyc("err5", 0,0,0,0,0,                1,0,0,            1,2'b00,32'h0,0,32'h0,        1,0,32'h55AA55AA);

        // reset while a read waits in the data phase and another sits in A
        cyc("rst0", 1,0,32'h20,2,0, 1,0,0,  1,2'b00,32'h00,0,32'h0, 0,0,0);
        cyc("rst1", 1,0,32'h24,2,0, 1,0,0,  1,2'b10,32'h20,2,32'h0, 0,0,0);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("rst2", 0, 2'b10, 32'h24, 2, 32'h0, 0, 0, 0);
        rst_n = 1'b0;
        expect_out("rst_async", 0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("rst_held", 0, 2'b00, 0, 0, 0, 0, 0, 0);
        hready = 1'b1;
        rst_n  = 1'b1;
        expect_out("rst_release", 0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("rst_edge1", 1, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("rst_edge2", 1, 2'b00, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
